// File: rtl/data_pack_if.sv
// Symbol-in / word-out stream bundle for the 7-to-32 bit packer.
// Handshake: a beat moves on a rising edge only when its valid and ready are both high; the source holds its payload stable while valid is high and ready is low.
interface data_pack_if #(
  parameter int SYM_W  = 7,
  parameter int WORD_W = 32
);
  localparam int BITS_W = $clog2(WORD_W) + 1;

  logic              valid_in;
  logic [SYM_W-1:0]  data_in;
  logic              sop_in;
  logic              eop_in;
  logic              ready_out;

  logic              valid_out;
  logic [WORD_W-1:0] data_out;
  logic              sop_out;
  logic              eop_out;
  logic [BITS_W-1:0] bits_out;
  logic              drop_out;
  logic              ready_in;

  // Environment side: produces symbols and consumes words.
  modport master (
    output valid_in, data_in, sop_in, eop_in, ready_in,
    input  ready_out, valid_out, data_out, sop_out, eop_out, bits_out, drop_out
  );

  // Packer side.
  modport slave (
    input  valid_in, data_in, sop_in, eop_in, ready_in,
    output ready_out, valid_out, data_out, sop_out, eop_out, bits_out, drop_out
  );
endinterface

// File: rtl/data_pack.sv
// Packs SYM_W-bit framed symbols LSB-first into WORD_W-bit words and flushes
// a zero-padded partial word, with its valid-bit count, at end of packet.
module data_pack #(
  parameter int SYM_W  = 7,
  parameter int WORD_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  data_pack_if.slave bus,
  output logic       dbg_state_o
);
  localparam int ACC_W  = WORD_W + SYM_W - 1;
  localparam int CNT_W  = $clog2(ACC_W + 1);
  localparam int BITS_W = $clog2(WORD_W) + 1;
  localparam logic [CNT_W-1:0] WORD_C = CNT_W'(WORD_W);
  localparam logic [CNT_W-1:0] SYM_C  = CNT_W'(SYM_W);

  typedef enum logic {ACCUM = 1'b0, FLUSH = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sop_pend_q, sop_pend_d;
  logic              live_q, live_d;
  logic              ovld_q, ovld_d;
  logic [WORD_W-1:0] odata_q, odata_d;
  logic              osop_q, osop_d;
  logic              oeop_q, oeop_d;
  logic [BITS_W-1:0] obits_q, obits_d;
  logic              drop_q, drop_d;

  logic             ready;
  logic             accept;
  logic             full;
  logic             load;
  logic [ACC_W-1:0] sym_ext;

  // live_q keeps ready low until the first edge after reset is released.
  assign ready   = live_q && (state_q == ACCUM) && (cnt_q < WORD_C);
  assign accept  = bus.valid_in && ready;
  assign full    = (cnt_q >= WORD_C);
  assign load    = (!ovld_q || bus.ready_in) &&
                   (full || ((state_q == FLUSH) && (cnt_q != '0)));
  assign sym_ext = ACC_W'(bus.data_in);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ACCUM;
      acc_q      <= '0;
      cnt_q      <= '0;
      sop_pend_q <= 1'b0;
      live_q     <= 1'b0;
      ovld_q     <= 1'b0;
      odata_q    <= '0;
      osop_q     <= 1'b0;
      oeop_q     <= 1'b0;
      obits_q    <= '0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      sop_pend_q <= sop_pend_d;
      live_q     <= live_d;
      ovld_q     <= ovld_d;
      odata_q    <= odata_d;
      osop_q     <= osop_d;
      oeop_q     <= oeop_d;
      obits_q    <= obits_d;
      drop_q     <= drop_d;
    end
  end

  // Load and accept never coincide: accept needs cnt < WORD_W, and in ACCUM
  // a word is only available once cnt >= WORD_W.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    sop_pend_d = sop_pend_q;
    live_d     = 1'b1;
    ovld_d     = ovld_q;
    odata_d    = odata_q;
    osop_d     = osop_q;
    oeop_d     = oeop_q;
    obits_d    = obits_q;
    drop_d     = 1'b0;

    if (load) begin
      ovld_d     = 1'b1;
      osop_d     = sop_pend_q;
      sop_pend_d = 1'b0;
      odata_d    = acc_q[WORD_W-1:0];
      if (full) begin
        obits_d = BITS_W'(WORD_W);
        acc_d   = acc_q >> WORD_W;
        cnt_d   = cnt_q - WORD_C;
        oeop_d  = (state_q == FLUSH) && (cnt_q == WORD_C);
        if (oeop_d) state_d = ACCUM;
      end else begin
        // Bits above cnt are always zero, so the partial word is already padded.
        obits_d = BITS_W'(cnt_q);
        oeop_d  = 1'b1;
        acc_d   = '0;
        cnt_d   = '0;
        state_d = ACCUM;
      end
    end else if (bus.ready_in) begin
      ovld_d = 1'b0;
    end

    if (accept) begin
      if (bus.sop_in && (cnt_q != '0)) begin
        acc_d  = sym_ext;
        cnt_d  = SYM_C;
        drop_d = 1'b1;
      end else begin
        acc_d = acc_q | (sym_ext << cnt_q);
        cnt_d = cnt_q + SYM_C;
      end
      if (bus.sop_in) sop_pend_d = 1'b1;
      if (bus.eop_in) state_d = FLUSH;
    end
  end

  assign bus.ready_out = ready;
  assign bus.valid_out = ovld_q;
  assign bus.data_out  = odata_q;
  assign bus.sop_out   = osop_q;
  assign bus.eop_out   = oeop_q;
  assign bus.bits_out  = obits_q;
  assign bus.drop_out  = drop_q;
  assign dbg_state_o   = (state_q == FLUSH);
endmodule

// File: tb/tb_data_pack.sv
// Bench for data_pack: directed framing cases plus random packets, scored
// against a bit-queue model of the packing rules.
module tb_data_pack;
  localparam int SYM_W  = 7;
  localparam int WORD_W = 32;
  localparam int W      = WORD_W + 1 + 1 + 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dbg_state;
  logic rand_rdy = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_drops = 0;
  int obs_drops = 0;
  int n_words   = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_log[$];
  bit           pend_bits[$];
  bit           m_sop_pend = 1'b0;

  always #5 clk = ~clk;

  data_pack_if #(.SYM_W(SYM_W), .WORD_W(WORD_W)) bus ();

  data_pack #(.SYM_W(SYM_W), .WORD_W(WORD_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [W-1:0] pk(input logic [31:0] d, input logic s,
                                      input logic e, input logic [5:0] b);
    return {d, s, e, b};
  endfunction

  // Reference: a packet is a flat bit stream cut into 32-bit words.
  function automatic void model_sym(input logic [SYM_W-1:0] d, input logic s, input logic e);
    logic [31:0] w;
    int n;
    if (s && pend_bits.size() > 0) begin
      pend_bits.delete();
      exp_drops++;
    end
    if (s) m_sop_pend = 1'b1;
    for (int i = 0; i < SYM_W; i++) pend_bits.push_back(d[i]);
    while (pend_bits.size() >= WORD_W) begin
      for (int i = 0; i < WORD_W; i++) w[i] = pend_bits.pop_front();
      exp_q.push_back(pk(w, m_sop_pend, e && (pend_bits.size() == 0), 6'd32));
      m_sop_pend = 1'b0;
    end
    if (e && pend_bits.size() > 0) begin
      w = '0;
      n = pend_bits.size();
      for (int i = 0; i < n; i++) w[i] = pend_bits.pop_front();
      exp_q.push_back(pk(w, m_sop_pend, 1'b1, 6'(n)));
      m_sop_pend = 1'b0;
    end
  endfunction

  function automatic void model_reset();
    pend_bits.delete();
    exp_q.delete();
    m_sop_pend = 1'b0;
  endfunction

  // Scoreboard: a word moves on the next rising edge if valid && ready now.
  always @(negedge clk) begin
    logic [W-1:0] got, e;
    if (!rst) begin
      if (bus.drop_out) obs_drops++;
      if (bus.valid_out && bus.ready_in) begin
        got = pk(bus.data_out, bus.sop_out, bus.eop_out, bus.bits_out);
        n_words++;
        obs_log.push_back(got);
        if (exp_q.size() == 0) begin
          chk("unexpected_word", got, '0);
        end else begin
          e = exp_q.pop_front();
          chk("word_data", got[W-1:8], e[W-1:8]);
          chk("word_sop",  got[7],     e[7]);
          chk("word_eop",  got[6],     e[6]);
          chk("word_bits", got[5:0],   e[5:0]);
        end
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (rand_rdy) bus.ready_in = ($urandom_range(0, 3) != 0);
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_sym(input logic [SYM_W-1:0] d, input logic s, input logic e);
    bit got = 1'b0;
    bus.valid_in = 1'b1;
    bus.data_in  = d;
    bus.sop_in   = s;
    bus.eop_in   = e;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      if (bus.ready_out) begin
        model_sym(d, s, e);
        got = 1'b1;
      end
    end
    if (!got) chk("sym_accept_timeout", 64'(got), 64'd1);
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    bus.sop_in   = 1'b0;
    bus.eop_in   = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int c = 0; c < 500; c++) begin
      if (exp_q.size() == 0 && !bus.valid_out) break;
      idle(1);
    end
    chk(tag, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, bus.valid_out, 1'b0);
    chk({tag, "_data"},  bus.data_out,  32'h0);
    chk({tag, "_sop"},   bus.sop_out,   1'b0);
    chk({tag, "_eop"},   bus.eop_out,   1'b0);
    chk({tag, "_bits"},  bus.bits_out,  6'd0);
    chk({tag, "_drop"},  bus.drop_out,  1'b0);
    chk({tag, "_ready"}, bus.ready_out, 1'b0);
  endtask

  initial begin
    int d0, w0;
    bus.valid_in = 1'b0;
    bus.data_in  = '0;
    bus.sop_in   = 1'b0;
    bus.eop_in   = 1'b0;
    bus.ready_in = 1'b1;

    // Reset values and ready rising one edge after release.
    #1;
    chk_all_zero("rst");
    idle(3);
    rst = 1'b0;
    #1;
    chk("rst_rel_ready_low", bus.ready_out, 1'b0);
    idle(1);
    chk("rst_rel_ready_high", bus.ready_out, 1'b1);

    // 1: single-symbol packet.
    obs_log.delete();
    send_sym(7'h7F, 1'b1, 1'b1);
    chk("t1_ready_flush", bus.ready_out, 1'b0);
    chk("t1_state_flush", dbg_state, 1'b1);
    idle(1);
    chk("t1_ready_back", bus.ready_out, 1'b1);
    chk("t1_valid", bus.valid_out, 1'b1);
    drain("t1_drain");
    chk("t1_n", 64'(obs_log.size()), 64'd1);
    chk("t1_w0", obs_log[0], pk(32'h0000007F, 1'b1, 1'b1, 6'd7));

    // 2: five symbols straddling a word boundary.
    obs_log.delete();
    for (int i = 1; i <= 5; i++) send_sym(7'(i), i == 1, i == 5);
    drain("t2_drain");
    chk("t2_n", 64'(obs_log.size()), 64'd2);
    chk("t2_w0", obs_log[0], pk(32'h5080C101, 1'b1, 1'b0, 6'd32));
    chk("t2_w1", obs_log[1], pk(32'h00000000, 1'b0, 1'b1, 6'd3));

    // 3: 224 bits, exactly seven words, no padded extra.
    obs_log.delete();
    for (int i = 0; i < 32; i++) send_sym(7'h7F, i == 0, i == 31);
    drain("t3_drain");
    chk("t3_n", 64'(obs_log.size()), 64'd7);
    chk("t3_last", obs_log[6], pk(32'hFFFFFFFF, 1'b0, 1'b1, 6'd32));

    // 4: same stream with a 20-cycle downstream stall.
    obs_log.delete();
    fork
      for (int i = 0; i < 32; i++) send_sym(7'h7F, i == 0, i == 31);
      begin
        for (int c = 0; c < 300 && !bus.valid_out; c++) idle(1);
        chk("t4_first_valid", bus.valid_out, 1'b1);
        bus.ready_in = 1'b0;
        for (int c = 0; c < 20; c++) begin
          idle(1);
          chk("t4_hold_data", bus.data_out, 32'hFFFFFFFF);
        end
        chk("t4_hold_valid", bus.valid_out, 1'b1);
        chk("t4_stall_ready", bus.ready_out, 1'b0);
        bus.ready_in = 1'b1;
      end
    join
    drain("t4_drain");
    chk("t4_n", 64'(obs_log.size()), 64'd7);

    // 5: unterminated packet overwritten by a new sop.
    obs_log.delete();
    d0 = obs_drops;
    send_sym(7'h11, 1'b1, 1'b0);
    send_sym(7'h22, 1'b0, 1'b0);
    send_sym(7'h33, 1'b1, 1'b1);
    drain("t5_drain");
    chk("t5_drop", 64'(obs_drops - d0), 64'd1);
    chk("t5_n", 64'(obs_log.size()), 64'd1);
    chk("t5_w0", obs_log[0], pk(32'h00000033, 1'b1, 1'b1, 6'd7));

    // 6: reset in the middle of a packet.
    send_sym(7'h01, 1'b1, 1'b0);
    send_sym(7'h02, 1'b0, 1'b0);
    send_sym(7'h03, 1'b0, 1'b0);
    rst = 1'b1;
    model_reset();
    #1;
    chk_all_zero("t6_rst");
    idle(3);
    rst = 1'b0;
    idle(1);
    obs_log.delete();
    send_sym(7'h2A, 1'b1, 1'b1);
    drain("t6_drain");
    chk("t6_n", 64'(obs_log.size()), 64'd1);
    chk("t6_w0", obs_log[0], pk(32'h0000002A, 1'b1, 1'b1, 6'd7));

    // Random packets with random downstream readiness and gaps.
    w0 = n_words;
    rand_rdy = 1'b1;
    for (int p = 0; p < 40; p++) begin
      int len, kind;
      len  = $urandom_range(1, 12);
      kind = $urandom_range(0, 7);
      for (int i = 0; i < len; i++) begin
        send_sym(7'($urandom_range(0, 127)), (i == 0) && (kind != 0),
                 (i == len - 1) && !((kind == 1) && (p < 39)));
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
    end
    rand_rdy = 1'b0;
    bus.ready_in = 1'b1;
    drain("rand_drain");
    chk("rand_drops", 64'(obs_drops), 64'(exp_drops));
    chk("rand_some_words", 64'(n_words > w0), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/data_pack.md
Name: data_pack

Overview:
- Transmit-side counterpart of data_unpack: accepts a stream of 7-bit symbols with sop/eop framing and packs them into 32-bit words.
- Bits are packed LSB-first and contiguously; symbols may straddle word boundaries.
- Sits upstream of the 32-bit link, feeding whatever data_unpack later re-expands.
- Flushes a zero-padded partial word at end of packet and reports how many bits of that word are valid.

Parameters:
- SYM_W, 7, input symbol width; must satisfy 1 <= SYM_W < WORD_W.
- WORD_W, 32, output word width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- valid_in  in  1  data_in/sop_in/eop_in are valid this cycle.
- data_in  in  SYM_W  input symbol.
- sop_in  in  1  symbol is the first of a packet.
- eop_in  in  1  symbol is the last of a packet.
- ready_out  out  1  block accepts a symbol this cycle.
- valid_out  out  1  output word valid.
- data_out  out  WORD_W  packed word.
- sop_out  out  1  word is the first word of a packet.
- eop_out  out  1  word is the last word of a packet.
- bits_out  out  $clog2(WORD_W)+1  number of valid bits in data_out (1..WORD_W); WORD_W on every non-final word.
- drop_out  out  1  one-cycle pulse: pending bits were discarded because sop_in arrived mid-packet.
- ready_in  in  1  downstream accepts the output word.

Behaviour:
- Reset (async, rst=1): every output is 0, including ready_out. Accumulator is cleared, count cnt=0, state ACCUM. ready_out rises on the first edge after rst deasserts.
- A symbol transfers when valid_in && ready_out at a rising edge. A word transfers when valid_out && ready_in at a rising edge.
- Accumulator: 38 bits (WORD_W+SYM_W-1). The new symbol is written at bit position cnt, then cnt += SYM_W.
- ready_out = (state==ACCUM) && (cnt < WORD_W).
- Output register:
  - Loads when (!valid_out || ready_in) and a word is available. Otherwise data_out, sop_out, eop_out and bits_out hold.
  - A word is available when cnt >= WORD_W, or when state==FLUSH and cnt > 0.
- Full-word load:
  - data_out = acc[WORD_W-1:0], bits_out = WORD_W.
  - acc shifts right by WORD_W and cnt -= WORD_W.
  - Load and accept in the same cycle are impossible, because ready_out is low whenever cnt >= WORD_W.
- Latency: the symbol that completes a word is accepted at edge t; valid_out is high after edge t+1 if the output register is free.
- sop_out is set on the first word loaded after a symbol with sop_in was accepted.
- State ACCUM, on accepting a symbol with eop_in: go to FLUSH.
- State FLUSH:
  - Emit full words while cnt >= WORD_W.
  - If 0 < cnt < WORD_W, emit one final word: unused high bits zero, bits_out = cnt, eop_out = 1. Then cnt=0, acc=0 and return to ACCUM.
  - If cnt reaches exactly 0 on a full-word load, that word carries eop_out=1 and bits_out=WORD_W; return to ACCUM.
  - ready_out stays 0 throughout FLUSH.
- sop_in && eop_in on the same symbol: single-symbol packet. sop_out and eop_out are both set on the same word.
- sop_in accepted while cnt > 0 in ACCUM (previous packet never ended):
  - Pending bits are discarded and drop_out pulses for 1 cycle.
  - The new symbol is placed at bit 0, so cnt = SYM_W.
  - A word already in the output register is unaffected.
- Symbols accepted without a preceding sop are packed normally; no sop_out is generated for them.
- Backpressure: with ready_in=0 the output word holds stable. The accumulator keeps filling until cnt >= WORD_W, then ready_out drops. No bits are ever lost or reordered.
- valid_in=0 cycles leave all state unchanged apart from pending loads/flushes.
- rst mid-packet: immediate return to reset values. Partial data is lost and no eop word is emitted.

Test Plan:
1. sop+eop single symbol 0x7F, ready_in=1 -> one word 0x0000007F with sop_out=1, eop_out=1, bits_out=7. ready_out is low for exactly the flush cycles, then high again.
2. Symbols 0x01,0x02,0x03,0x04,0x05, with sop on 0x01 and eop on 0x05, ready_in=1:
   - Word 0x5080C101 with sop_out=1, eop_out=0, bits_out=32.
   - Then word 0x00000000 with eop_out=1, bits_out=3.
3. 32 symbols of 0x7F (sop on first, eop on last) -> exactly 7 words of 0xFFFFFFFF. Only the first has sop_out; only the 7th has eop_out, with bits_out=32. No padded extra word.
4. Same stream as 3 with ready_in=0 for 20 cycles after the first valid_out:
   - data_out holds 0xFFFFFFFF and ready_out stalls low once cnt >= 32.
   - After ready_in rises, the remaining 6 words drain with no loss.
5. Packet sop,0x11,0x22 (no eop), then a symbol 0x33 with sop+eop -> drop_out pulses once, and the only word out is 0x00000033 with sop_out=1, eop_out=1, bits_out=7.
6. Assert rst after 3 symbols of a packet -> all outputs 0 immediately. After release, a fresh sop+eop packet of 0x2A yields 0x0000002A and nothing from before the reset.
